// File: rtl/sound_pkg.sv
// Shared definitions for the sound-CPU mailbox: counter width helper and the
// per-direction status record kept by each FIFO.
package sound_pkg;

    // Widest occupancy counter needed: DEPTH is at most 64, so 0..64 needs 7 bits.
    localparam int CNT_MAX_W = 7;

    // Occupancy counter width for a FIFO of the given depth (counts 0..depth).
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Registered status of one mailbox direction. The count field is sized for
    // the largest legal depth; a FIFO only ever reaches values up to its own DEPTH.
    typedef struct packed {
        logic                 rdy;
        logic                 full;
        logic                 ovf;
        logic [CNT_MAX_W-1:0] count;
    } mbox_stat_t;

endpackage

// File: rtl/sound_mailbox_fifo.sv
// One direction of the sound mailbox: a show-ahead FIFO with sticky overflow,
// optional latch-style overwrite when full, and a held last-popped value so
// the read port keeps its previous data while empty.
module mailbox_fifo
    import sound_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int OVERWRITE = 0
) (
    input  logic                      clk_sys,
    input  logic                      clr_i,
    input  logic                      wr_i,
    input  logic [WIDTH-1:0]          din_i,
    input  logic                      rd_i,
    output logic [WIDTH-1:0]          dout_o,
    output logic                      rdy_o,
    output logic                      ovf_o,
    output logic [cnt_w(DEPTH)-1:0]   count_o
);

    localparam int CW = cnt_w(DEPTH);
    // A depth-1 FIFO still gets a 1-bit pointer; it simply never leaves 0.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]        LAST_C  = PW'(DEPTH - 1);
    localparam logic [CNT_MAX_W-1:0] DEPTH_C = CNT_MAX_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    wprev;
    logic [WIDTH-1:0] last_q, last_d;
    mbox_stat_t       stat_q, stat_d;
    logic             do_pop, do_push, lost, do_ovw;

    // Pointers wrap modulo DEPTH, which need not fill the pointer's bit range.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    // Next-state: decide which of push/pop take effect and derive status.
    always_comb begin
        // A pop frees a slot first, so a push alongside a pop on a full FIFO fits.
        do_pop  = rd_i && stat_q.rdy;
        do_push = wr_i && (!stat_q.full || do_pop);
        lost    = wr_i && stat_q.full && !do_pop;
        do_ovw  = lost && (OVERWRITE != 0);
        wprev   = (wptr_q == '0) ? LAST_C : wptr_q - 1'b1;

        wptr_d  = do_push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = do_pop  ? ptr_inc(rptr_q) : rptr_q;
        last_d  = do_pop  ? mem_q[rptr_q]   : last_q;

        stat_d = stat_q;
        unique case ({do_push, do_pop})
            2'b10:   stat_d.count = stat_q.count + 1'b1;
            2'b01:   stat_d.count = stat_q.count - 1'b1;
            default: stat_d.count = stat_q.count;
        endcase
        stat_d.rdy  = (stat_d.count != '0);
        stat_d.full = (stat_d.count == DEPTH_C);
        stat_d.ovf  = stat_q.ovf | lost;
    end

    // Control state: pointers, status and held read value; clear wins over traffic.
    always_ff @(posedge clk_sys) begin
        if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            last_q <= '0;
            stat_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            last_q <= last_d;
            stat_q <= stat_d;
        end
    end

    // Storage: normal pushes append; an overwrite replaces the newest entry.
    always_ff @(posedge clk_sys) begin
        if (!clr_i) begin
            if (do_push) begin
                mem_q[wptr_q] <= din_i;
            end else if (do_ovw) begin
                mem_q[wprev] <= din_i;
            end
        end
    end

    // While empty the read port keeps showing the last value popped.
    assign dout_o  = stat_q.rdy ? mem_q[rptr_q] : last_q;
    assign rdy_o   = stat_q.rdy;
    assign ovf_o   = stat_q.ovf;
    assign count_o = stat_q.count[CW-1:0];

endmodule

// File: rtl/sound_mailbox.sv
// Bidirectional command/reply mailbox between the main CPU and the V35 sound
// CPU. Two independent FIFOs; this level only fans out flush, derives the
// sound interrupt and full flag, and maps the ports.
module sound_mailbox
    import sound_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int OVERWRITE = 0
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      flush,
    // main CPU side
    input  logic                      main_wr,
    input  logic [WIDTH-1:0]          main_din,
    input  logic                      main_rd,
    output logic [WIDTH-1:0]          main_dout,
    output logic                      main_rdy,
    output logic                      main_full,
    output logic                      main_ovf,
    output logic [cnt_w(DEPTH)-1:0]   main_count,
    // sound CPU side
    input  logic                      snd_wr,
    input  logic [WIDTH-1:0]          snd_din,
    input  logic                      snd_rd,
    output logic [WIDTH-1:0]          snd_dout,
    output logic                      snd_rdy,
    output logic                      snd_irq_n,
    output logic                      snd_ovf,
    output logic [cnt_w(DEPTH)-1:0]   snd_count
);

    localparam int CW = cnt_w(DEPTH);

    logic clr;

    // Flush behaves exactly like reset for both directions.
    assign clr = reset | flush;

    // main -> sound direction: written by the main CPU, read by the V35.
    mailbox_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .OVERWRITE (OVERWRITE)
    ) u_m2s (
        .clk_sys (clk_sys),
        .clr_i   (clr),
        .wr_i    (main_wr),
        .din_i   (main_din),
        .rd_i    (snd_rd),
        .dout_o  (snd_dout),
        .rdy_o   (snd_rdy),
        .ovf_o   (main_ovf),
        .count_o (snd_count)
    );

    // sound -> main direction: written by the V35, read by the main CPU.
    mailbox_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .OVERWRITE (OVERWRITE)
    ) u_s2m (
        .clk_sys (clk_sys),
        .clr_i   (clr),
        .wr_i    (snd_wr),
        .din_i   (snd_din),
        .rd_i    (main_rd),
        .dout_o  (main_dout),
        .rdy_o   (main_rdy),
        .ovf_o   (snd_ovf),
        .count_o (main_count)
    );

    // The main CPU only needs to know when its outgoing queue is full.
    assign main_full = (snd_count == CW'(DEPTH));

    // snd_rdy is a flop loaded from the post-edge count, so the inverted
    // interrupt is glitch-free and falls in the same cycle rdy rises.
    assign snd_irq_n = ~snd_rdy;

endmodule
